// File: rtl/riscv_arb_pkg.sv
// Shared encodings for the multi-channel memory arbiter.
// Included by both the top-level FSM and the channel picker.
package riscv_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_DONE = 2'd2
    } arb_state_e;

    localparam int PRIO_RR    = 0;
    localparam int PRIO_FIXED = 1;

endpackage

// File: rtl/riscv_rr_picker.sv
// Combinational winner select: rotate the request vector by the pointer,
// priority-encode the lowest set bit, then rotate the index back.
module riscv_rr_picker
    import riscv_arb_pkg::*;
#(
    parameter  int NCH = 2,
    localparam int CW  = $clog2(NCH)
) (
    input  logic [NCH-1:0] i_req,
    input  logic [CW-1:0]  i_ptr,
    input  logic           i_mode,
    output logic [NCH-1:0] o_gnt,
    output logic [CW-1:0]  o_idx
);

    logic [CW-1:0]  w_base;
    logic [NCH-1:0] w_rot;
    logic [CW-1:0]  w_off;
    logic           w_found;
    logic [CW:0]    w_sum;

    // Fixed priority is round-robin with the pointer pinned to channel 0.
    assign w_base = (i_mode == 1'(PRIO_FIXED)) ? '0 : i_ptr;
    assign w_rot  = NCH'({i_req, i_req} >> w_base);

    always_comb begin
        w_found = 1'b0;
        w_off   = '0;
        for (int i = 0; i < NCH; i++) begin
            if (!w_found && w_rot[i]) begin
                w_found = 1'b1;
                w_off   = CW'(i);
            end
        end
    end

    assign w_sum = {1'b0, w_off} + {1'b0, w_base};
    assign o_idx = (w_sum >= (CW+1)'(NCH)) ? CW'(w_sum - (CW+1)'(NCH)) : CW'(w_sum);

    always_comb begin
        o_gnt = '0;
        for (int c = 0; c < NCH; c++) begin
            o_gnt[c] = w_found && (o_idx == CW'(c));
        end
    end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Merges N cache block-request channels onto one memory port.
// IDLE -> BUSY (latched request on memory) -> DONE (one quiet cycle) -> IDLE.
module riscv_mem_arbiter
    import riscv_arb_pkg::*;
#(
    parameter int NCH        = 2,
    parameter int DATA_WIDTH = 128,
    parameter int S_ADDR     = 10,
    parameter int PRIO_MODE  = 0
) (
    input  logic                      i_riscv_arb_clk,
    input  logic                      i_riscv_arb_rst,
    input  logic [NCH-1:0]            i_riscv_arb_rden,
    input  logic [NCH-1:0]            i_riscv_arb_wren,
    input  logic [NCH*S_ADDR-1:0]     i_riscv_arb_addr,
    input  logic [NCH*DATA_WIDTH-1:0] i_riscv_arb_wdata,
    output logic [NCH-1:0]            o_riscv_arb_ready,
    output logic [DATA_WIDTH-1:0]     o_riscv_arb_rdata,
    output logic [NCH-1:0]            o_riscv_arb_gnt,
    output logic                      o_riscv_arb_mem_rden,
    output logic                      o_riscv_arb_mem_wren,
    output logic [S_ADDR-1:0]         o_riscv_arb_mem_addr,
    output logic [DATA_WIDTH-1:0]     o_riscv_arb_mem_wdata,
    input  logic                      i_riscv_arb_mem_ready,
    input  logic [DATA_WIDTH-1:0]     i_riscv_arb_mem_data_out
);

    localparam int CW = $clog2(NCH);

    arb_state_e            r_state, w_next;
    logic [CW-1:0]         r_ptr, r_gidx, w_pick_idx;
    logic [NCH-1:0]        r_gnt, w_req, w_pick_gnt;
    logic                  r_wr;
    logic [S_ADDR-1:0]     r_addr, w_sel_addr;
    logic [DATA_WIDTH-1:0] r_wdata, w_sel_wdata;
    logic                  w_busy, w_start, w_done;

    assign w_req = i_riscv_arb_rden | i_riscv_arb_wren;

    riscv_rr_picker #(.NCH(NCH)) u_picker (
        .i_req  (w_req),
        .i_ptr  (r_ptr),
        .i_mode (1'(PRIO_MODE)),
        .o_gnt  (w_pick_gnt),
        .o_idx  (w_pick_idx)
    );

    always_comb begin
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int c = 0; c < NCH; c++) begin
            if (w_pick_gnt[c]) begin
                w_sel_addr  = i_riscv_arb_addr[c*S_ADDR +: S_ADDR];
                w_sel_wdata = i_riscv_arb_wdata[c*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_busy  = (r_state == ARB_BUSY);
    assign w_start = (r_state == ARB_IDLE) && (|w_req);
    assign w_done  = w_busy && i_riscv_arb_mem_ready;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ARB_IDLE: if (|w_req) w_next = ARB_BUSY;
            ARB_BUSY: if (i_riscv_arb_mem_ready) w_next = ARB_DONE;
            ARB_DONE: w_next = ARB_IDLE;
            default:  w_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge i_riscv_arb_clk or negedge i_riscv_arb_rst) begin
        if (!i_riscv_arb_rst) begin
            r_state <= ARB_IDLE;
            r_ptr   <= '0;
            r_gidx  <= '0;
            r_gnt   <= '0;
            r_wr    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_gnt   <= w_pick_gnt;
                r_gidx  <= w_pick_idx;
                // A channel raising both rden and wren is served as a write.
                r_wr    <= |(i_riscv_arb_wren & w_pick_gnt);
                r_addr  <= w_sel_addr;
                r_wdata <= w_sel_wdata;
            end
            if (w_done) begin
                r_ptr <= (r_gidx == CW'(NCH-1)) ? '0 : r_gidx + CW'(1);
            end
            if (r_state == ARB_DONE) begin
                r_gnt <= '0;
            end
        end
    end

    // Memory side sees only latched values, and only while BUSY.
    assign o_riscv_arb_mem_rden  = w_busy & ~r_wr;
    assign o_riscv_arb_mem_wren  = w_busy &  r_wr;
    assign o_riscv_arb_mem_addr  = w_busy ? r_addr  : '0;
    assign o_riscv_arb_mem_wdata = w_busy ? r_wdata : '0;

    assign o_riscv_arb_gnt   = r_gnt;
    assign o_riscv_arb_ready = w_done ? r_gnt : '0;
    assign o_riscv_arb_rdata = w_done ? i_riscv_arb_mem_data_out : '0;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Bench for riscv_mem_arbiter: three instances (2ch RR, 2ch fixed, 3ch RR)
// sharing one clock/reset, each backed by a small latency-programmable memory.
module tb_riscv_mem_arbiter;

    localparam int DW = 128;
    localparam int SA = 10;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [1:0]      a_rden, a_wren, a_gnt, a_rdy;
    logic [2*SA-1:0] a_addr;
    logic [2*DW-1:0] a_wdata;
    logic [DW-1:0]   a_rdata;
    logic [1:0]      b_rden, b_wren, b_gnt, b_rdy;
    logic [2*SA-1:0] b_addr;
    logic [2*DW-1:0] b_wdata;
    logic [DW-1:0]   b_rdata;
    logic [2:0]      c_rden, c_wren, c_gnt, c_rdy;
    logic [3*SA-1:0] c_addr;
    logic [3*DW-1:0] c_wdata;
    logic [DW-1:0]   c_rdata;

    logic          mrd [3];
    logic          mwr [3];
    logic          mrdy[3];
    logic [SA-1:0] maddr[3];
    logic [DW-1:0] mwd [3];
    logic [DW-1:0] mdat[3];

    int            lat[3];
    int            cnt[3];
    logic          ov_en;
    logic [DW-1:0] ov_data;
    int            n_chk = 0;
    int            n_err = 0;

    riscv_mem_arbiter #(.NCH(2), .DATA_WIDTH(DW), .S_ADDR(SA), .PRIO_MODE(0)) dut_a (
        .i_riscv_arb_clk(clk), .i_riscv_arb_rst(rst_n),
        .i_riscv_arb_rden(a_rden), .i_riscv_arb_wren(a_wren),
        .i_riscv_arb_addr(a_addr), .i_riscv_arb_wdata(a_wdata),
        .o_riscv_arb_ready(a_rdy), .o_riscv_arb_rdata(a_rdata), .o_riscv_arb_gnt(a_gnt),
        .o_riscv_arb_mem_rden(mrd[0]), .o_riscv_arb_mem_wren(mwr[0]),
        .o_riscv_arb_mem_addr(maddr[0]), .o_riscv_arb_mem_wdata(mwd[0]),
        .i_riscv_arb_mem_ready(mrdy[0]), .i_riscv_arb_mem_data_out(mdat[0]));

    riscv_mem_arbiter #(.NCH(2), .DATA_WIDTH(DW), .S_ADDR(SA), .PRIO_MODE(1)) dut_b (
        .i_riscv_arb_clk(clk), .i_riscv_arb_rst(rst_n),
        .i_riscv_arb_rden(b_rden), .i_riscv_arb_wren(b_wren),
        .i_riscv_arb_addr(b_addr), .i_riscv_arb_wdata(b_wdata),
        .o_riscv_arb_ready(b_rdy), .o_riscv_arb_rdata(b_rdata), .o_riscv_arb_gnt(b_gnt),
        .o_riscv_arb_mem_rden(mrd[1]), .o_riscv_arb_mem_wren(mwr[1]),
        .o_riscv_arb_mem_addr(maddr[1]), .o_riscv_arb_mem_wdata(mwd[1]),
        .i_riscv_arb_mem_ready(mrdy[1]), .i_riscv_arb_mem_data_out(mdat[1]));

    riscv_mem_arbiter #(.NCH(3), .DATA_WIDTH(DW), .S_ADDR(SA), .PRIO_MODE(0)) dut_c (
        .i_riscv_arb_clk(clk), .i_riscv_arb_rst(rst_n),
        .i_riscv_arb_rden(c_rden), .i_riscv_arb_wren(c_wren),
        .i_riscv_arb_addr(c_addr), .i_riscv_arb_wdata(c_wdata),
        .o_riscv_arb_ready(c_rdy), .o_riscv_arb_rdata(c_rdata), .o_riscv_arb_gnt(c_gnt),
        .o_riscv_arb_mem_rden(mrd[2]), .o_riscv_arb_mem_wren(mwr[2]),
        .o_riscv_arb_mem_addr(maddr[2]), .o_riscv_arb_mem_wdata(mwd[2]),
        .i_riscv_arb_mem_ready(mrdy[2]), .i_riscv_arb_mem_data_out(mdat[2]));

    function automatic logic [DW-1:0] rdfun(int d, logic [SA-1:0] a);
        if (d == 0 && ov_en) return ov_data;
        return {4{22'h2B5A11, a}};
    endfunction

    // Memory: pulses ready lat[d] cycles after it first sees a request.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 3; d++) begin
                mrdy[d] <= 1'b0;
                cnt[d]  <= 0;
                mdat[d] <= '0;
            end
        end else begin
            for (int d = 0; d < 3; d++) begin
                if (mrdy[d]) begin
                    mrdy[d] <= 1'b0;
                    cnt[d]  <= 0;
                end else if (mrd[d] || mwr[d]) begin
                    if (cnt[d] >= lat[d] - 1) begin
                        mrdy[d] <= 1'b1;
                        mdat[d] <= mwr[d] ? '0 : rdfun(d, maddr[d]);
                    end else begin
                        cnt[d] <= cnt[d] + 1;
                    end
                end
            end
        end
    end

    task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [2:0] gnt_of(int d);
        case (d)
            0:       return {1'b0, a_gnt};
            1:       return {1'b0, b_gnt};
            default: return c_gnt;
        endcase
    endfunction

    function automatic logic [2:0] rdy_of(int d);
        case (d)
            0:       return {1'b0, a_rdy};
            1:       return {1'b0, b_rdy};
            default: return c_rdy;
        endcase
    endfunction

    function automatic logic [DW-1:0] rdata_of(int d);
        case (d)
            0:       return a_rdata;
            1:       return b_rdata;
            default: return c_rdata;
        endcase
    endfunction

    task automatic wait_gnt(int d, output logic [2:0] g);
        g = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            g = gnt_of(d);
            if (g != 0) return;
        end
        n_chk++; n_err++;
        $display("FAIL wait_gnt dut%0d: got no grant, required one within 40 cycles", d);
    endtask

    task automatic wait_rdy(int d, output logic [2:0] r, output logic [DW-1:0] rd);
        r = '0; rd = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            r = rdy_of(d);
            if (r != 0) begin
                rd = rdata_of(d);
                return;
            end
        end
        n_chk++; n_err++;
        $display("FAIL wait_rdy dut%0d: got no ready, required one within 40 cycles", d);
    endtask

    function automatic int pick(logic [2:0] rq, int p);
        for (int k = 0; k < 3; k++) if (rq[(p + k) % 3]) return (p + k) % 3;
        return 0;
    endfunction

    typedef struct {
        logic [1:0] rden;
        logic [1:0] wren;
        int         ch;
        logic       wr;
    } vec_t;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t          tbl[6];
        logic [2:0]    g, r, oh, prev;
        logic [DW-1:0] rd;
        logic [DW-1:0] W0, W1, WV;
        int            npulse, ph, mg, mptr, bc;

        W0 = {4{32'hC0DE_0000}};
        W1 = {4{32'h1234_ABCD}};
        WV = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        tbl[0] = '{2'b01, 2'b00, 0, 1'b0};
        tbl[1] = '{2'b11, 2'b00, 1, 1'b0};
        tbl[2] = '{2'b10, 2'b01, 0, 1'b1};
        tbl[3] = '{2'b00, 2'b11, 1, 1'b1};
        tbl[4] = '{2'b10, 2'b10, 1, 1'b1};
        tbl[5] = '{2'b11, 2'b00, 0, 1'b0};

        rst_n = 1'b0;
        a_rden = '0; a_wren = '0; a_addr = '0; a_wdata = '0;
        b_rden = '0; b_wren = '0; b_addr = '0; b_wdata = '0;
        c_rden = '0; c_wren = '0; c_addr = '0; c_wdata = '0;
        lat[0] = 2; lat[1] = 1; lat[2] = 2;
        ov_en = 1'b0; ov_data = '0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("rst_gnt",   gnt_of(d), 0);
            chk("rst_ready", rdy_of(d), 0);
            chk("rst_rden",  mrd[d], 0);
            chk("rst_wren",  mwr[d], 0);
            chk("rst_addr",  maddr[d], 0);
            chk("rst_wdata", mwd[d], 0);
            chk("rst_rdata", rdata_of(d), 0);
        end
        rst_n = 1'b1;

        // Single read on ch1, memory latency 3
        ov_en = 1'b1; ov_data = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF; lat[0] = 3;
        @(negedge clk);
        a_rden = 2'b10; a_addr[SA +: SA] = 10'h2A5;
        @(negedge clk);
        chk("rd1_gnt",  a_gnt, 2'b10);
        chk("rd1_rden", mrd[0], 1);
        chk("rd1_wren", mwr[0], 0);
        chk("rd1_addr", maddr[0], 10'h2A5);
        npulse = 0;
        for (int i = 0; i < 10; i++) begin
            if (a_rdy != 0) begin
                npulse++;
                chk("rd1_ready", a_rdy, 2'b10);
                chk("rd1_rdata", a_rdata, ov_data);
                a_rden = '0;
            end
            @(negedge clk);
        end
        chk("rd1_pulses", npulse, 1);
        ov_en = 1'b0;

        // Round-robin contention: both channels hold requests
        lat[0] = 2; a_rden = 2'b11; a_addr = {10'h155, 10'h0AA};
        for (int t = 0; t < 4; t++) begin
            wait_gnt(0, g);
            chk("rr_gnt", g, (t % 2 == 0) ? 3'd1 : 3'd2);
            wait_rdy(0, r, rd);
            chk("rr_ready", r, g);
            chk("rr_rdata", rd, rdfun(0, (t % 2 == 0) ? 10'h0AA : 10'h155));
            if (t == 3) a_rden = '0;
            @(negedge clk);
        end

        // Table-driven single transactions on the 2-channel RR instance
        a_addr = {10'h31C, 10'h0C3}; a_wdata = {W1, W0};
        @(negedge clk);
        for (int e = 0; e < 6; e++) begin
            a_rden = tbl[e].rden; a_wren = tbl[e].wren;
            wait_gnt(0, g);
            chk("tbl_gnt",  g, 3'(1 << tbl[e].ch));
            chk("tbl_wren", mwr[0], tbl[e].wr);
            chk("tbl_rden", mrd[0], !tbl[e].wr);
            chk("tbl_addr", maddr[0], tbl[e].ch ? 10'h31C : 10'h0C3);
            if (tbl[e].wr) chk("tbl_wdata", mwd[0], tbl[e].ch ? W1 : W0);
            wait_rdy(0, r, rd);
            chk("tbl_ready", r, 3'(1 << tbl[e].ch));
            chk("tbl_rdata", rd, tbl[e].wr ? '0 : rdfun(0, tbl[e].ch ? 10'h31C : 10'h0C3));
            a_rden = '0; a_wren = '0;
            @(negedge clk);
            chk("tbl_done", {mrd[0], mwr[0], a_rdy}, 0);
            @(negedge clk);
            chk("tbl_idle", a_gnt, 0);
        end

        // Write with rden also set; wdata changes mid-transaction
        lat[0] = 4; a_rden = 2'b10; a_wren = 2'b10; a_wdata[DW +: DW] = WV;
        wait_gnt(0, g);
        chk("wr_gnt",   g, 3'd2);
        chk("wr_wren",  mwr[0], 1);
        chk("wr_rden",  mrd[0], 0);
        chk("wr_wdata", mwd[0], WV);
        @(negedge clk);
        a_wdata[DW +: DW] = ~WV;
        @(negedge clk);
        chk("wr_wdata_hold", mwd[0], WV);
        wait_rdy(0, r, rd);
        chk("wr_ready", r, 3'd2);
        a_rden = '0; a_wren = '0;
        @(negedge clk);

        // Fixed priority: ch0 wins while it keeps requesting
        b_rden = 2'b11; b_addr = {10'h222, 10'h111};
        for (int t = 0; t < 3; t++) begin
            wait_gnt(1, g);
            chk("fx_gnt", g, 3'd1);
            wait_rdy(1, r, rd);
            chk("fx_ready", r, 3'd1);
            if (t == 2) b_rden = 2'b10;
            @(negedge clk);
        end
        wait_gnt(1, g);
        chk("fx_gnt_ch1", g, 3'd2);
        wait_rdy(1, r, rd);
        chk("fx_ready_ch1", r, 3'd2);
        b_rden = '0;

        // Three-channel wrap: move pointer to 2, then ch2 and ch0 contend
        c_addr = {10'h3C3, 10'h2B2, 10'h1A1};
        c_rden = 3'b010;
        wait_gnt(2, g);
        chk("wrap_pre", g, 3'b010);
        wait_rdy(2, r, rd);
        c_rden = '0;
        repeat (2) @(negedge clk);
        c_rden = 3'b101;
        wait_gnt(2, g);
        chk("wrap_gnt2", g, 3'b100);
        wait_rdy(2, r, rd);
        chk("wrap_rdy2", r, 3'b100);
        c_rden = 3'b001;
        @(negedge clk);
        wait_gnt(2, g);
        chk("wrap_gnt0", g, 3'b001);
        wait_rdy(2, r, rd);
        c_rden = '0;
        repeat (3) @(negedge clk);

        // Randomized traffic on the 3-channel instance vs. a transaction-level model
        ph = 0; mg = 0; mptr = 1; bc = 0; prev = '0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk);
            g = c_gnt; r = c_rdy;
            oh = 3'(1 << mg);
            if (ph == 0) begin
                if (prev != 0) begin
                    mg = pick(prev, mptr); oh = 3'(1 << mg);
                    chk("rnd_gnt", g, oh);
                    chk("rnd_op", {mrd[2], mwr[2]}, {!c_wren[mg], c_wren[mg]});
                    chk("rnd_addr", maddr[2], c_addr[mg*SA +: SA]);
                    lat[2] = int'($urandom_range(1, 4));
                    ph = 1; bc = 0;
                end else begin
                    chk("rnd_idle", {g, mrd[2], mwr[2]}, 0);
                end
            end else if (ph == 1) begin
                chk("rnd_busy_gnt", g, oh);
                chk("rnd_busy_op", {mrd[2], mwr[2]}, {!c_wren[mg], c_wren[mg]});
                chk("rnd_busy_addr", maddr[2], c_addr[mg*SA +: SA]);
                if (c_wren[mg]) chk("rnd_wdata", mwd[2], c_wdata[mg*DW +: DW]);
                if (mrdy[2]) begin
                    chk("rnd_ready", r, oh);
                    chk("rnd_rdata", c_rdata, c_wren[mg] ? '0 : rdfun(2, c_addr[mg*SA +: SA]));
                    c_rden[mg] = 1'b0; c_wren[mg] = 1'b0;
                    mptr = (mg + 1) % 3;
                    ph = 2;
                end else begin
                    chk("rnd_noready", r, 0);
                    bc++;
                    if (bc > 50) begin
                        n_chk++; n_err++;
                        $display("FAIL rnd_timeout: got no completion, required one within 50 cycles");
                        break;
                    end
                end
            end else if (ph == 2) begin
                chk("rnd_done", {mrd[2], mwr[2], r}, 0);
                ph = 3;
            end else begin
                chk("rnd_idle_gnt", g, 0);
                ph = 0;
            end
            for (int ch = 0; ch < 3; ch++) begin
                if (!(c_rden[ch] | c_wren[ch]) && $urandom_range(0, 2) == 0) begin
                    int op;
                    op = int'($urandom_range(0, 2));
                    c_rden[ch] = (op != 1);
                    c_wren[ch] = (op != 0);
                    c_addr[ch*SA +: SA]  = SA'($urandom);
                    c_wdata[ch*DW +: DW] = {$urandom, $urandom, $urandom, $urandom};
                end
            end
            prev = c_rden | c_wren;
        end
        c_rden = '0; c_wren = '0;

        // Reset while BUSY: pointer first moved off 0 by a ch0 transaction
        lat[0] = 1; a_rden = 2'b01; a_addr = {10'h0F0, 10'h00F};
        wait_gnt(0, g);
        wait_rdy(0, r, rd);
        a_rden = '0;
        repeat (2) @(negedge clk);
        lat[0] = 10; a_rden = 2'b01;
        wait_gnt(0, g);
        chk("rb_rden", mrd[0], 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rb_gnt",   a_gnt, 0);
        chk("rb_ready", a_rdy, 0);
        chk("rb_rden0", mrd[0], 0);
        chk("rb_wren0", mwr[0], 0);
        chk("rb_addr",  maddr[0], 0);
        chk("rb_wdata", mwd[0], 0);
        chk("rb_rdata", a_rdata, 0);
        @(negedge clk);
        rst_n = 1'b1;
        a_rden = 2'b11;
        chk("rb_idle", a_gnt, 0);
        wait_gnt(0, g);
        chk("rb_regrant", g, 3'd1);
        wait_rdy(0, r, rd);
        chk("rb_ready2", r, 3'd1);
        a_rden = '0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
